// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one single-port sram between NUM_REQ requesters
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester handshake; ready is a one-hot grant, only in IDLE
//   req_wr                per-requester 1=write, 0=read
//   req_addr, req_wdata   packed per-requester address / write data
//   rsp_valid, rsp_rdata  one-cycle read-data strobe to the owner, shared data
//   sram_cs/wr/oe/addr    registered sram control pins
//   sram_dq_o/dq_oe/dq_i  tristate data bus pieces (drive value, drive enable, sampled value)
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           sram_cs,
  output logic                           sram_wr,
  output logic                           sram_oe,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  output logic [DATA_WIDTH-1:0]          sram_dq_o,
  output logic                           sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]          sram_dq_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, TURN} state_t;

  state_t                  state, state_nx;
  logic [PW-1:0]           ptr, ptr_nx;
  logic [PW-1:0]           owner, owner_nx;
  logic [ADDR_WIDTH-1:0]   lat_addr, lat_addr_nx;

  logic [PW-1:0]           gnt;
  logic                    gnt_found;
  logic [NUM_REQ-1:0]      gnt_oh;

  // Next values of the registered outputs; every sram pin comes straight from a flop.
  logic                    cs_nx, wr_nx, oe_nx, dq_oe_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   dq_o_nx, rdata_nx;
  logic [NUM_REQ-1:0]      rsp_valid_nx;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt       = cand;
      end
    end
  end

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  // Grant is combinational for the IDLE cycle; forced low while reset is held
  // so every output reads 0 during reset.
  assign req_ready = (state == IDLE && gnt_found && rst_n) ? gnt_oh : '0;

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    owner_nx     = owner;
    lat_addr_nx  = lat_addr;
    cs_nx        = 1'b0;
    wr_nx        = 1'b0;
    oe_nx        = 1'b0;
    dq_oe_nx     = 1'b0;
    addr_nx      = '0;
    dq_o_nx      = '0;
    rdata_nx     = '0;
    rsp_valid_nx = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          ptr_nx      = (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + PW'(1);
          owner_nx    = gnt;
          lat_addr_nx = req_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
          cs_nx       = 1'b1;
          addr_nx     = req_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
          if (req_wr[gnt]) begin
            state_nx = WR;
            wr_nx    = 1'b1;
            dq_oe_nx = 1'b1;
            dq_o_nx  = req_wdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            state_nx = RD_ADDR;
            oe_nx    = 1'b1;
          end
        end
      end
      WR: state_nx = IDLE;
      RD_ADDR: begin
        state_nx = RD_CAP;
        cs_nx    = 1'b1;
        oe_nx    = 1'b1;
        addr_nx  = lat_addr;
      end
      RD_CAP: begin
        // The sram has had a full cycle to drive dq; sample it at the end of RD_CAP.
        state_nx            = TURN;
        rsp_valid_nx[owner] = 1'b1;
        rdata_nx            = sram_dq_i;
      end
      TURN: state_nx = IDLE;  // bus left undriven for one cycle before any write
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      lat_addr   <= '0;
      sram_cs    <= 1'b0;
      sram_wr    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      owner      <= owner_nx;
      lat_addr   <= lat_addr_nx;
      sram_cs    <= cs_nx;
      sram_wr    <= wr_nx;
      sram_oe    <= oe_nx;
      sram_addr  <= addr_nx;
      sram_dq_o  <= dq_o_nx;
      sram_dq_oe <= dq_oe_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_rdata  <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_wr, rsp_valid;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  rsp_rdata, sram_addr, sram_dq_o, sram_dq_i;
  logic        sram_cs, sram_wr, sram_oe, sram_dq_oe;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_oe(sram_oe), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
  );

  typedef struct {
    logic [1:0] v, w;
    logic [7:0] a0, a1, w0, w1, dqi;
    logic [1:0] e_rdy, e_rsp;
    logic [7:0] e_rd;
    logic       e_cs, e_wr, e_oe;
    logic [7:0] e_addr, e_dqo;
    logic       e_dqoe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] v, w, input logic [7:0] a0, a1, w0, w1, dqi,
                              input logic [1:0] er, ers, input logic [7:0] erd,
                              input logic ecs, ewr, eoe, input logic [7:0] ea, edq, input logic edqoe);
    vec_t r;
    r.v = v; r.w = w; r.a0 = a0; r.a1 = a1; r.w0 = w0; r.w1 = w1; r.dqi = dqi;
    r.e_rdy = er; r.e_rsp = ers; r.e_rd = erd; r.e_cs = ecs; r.e_wr = ewr; r.e_oe = eoe;
    r.e_addr = ea; r.e_dqo = edq; r.e_dqoe = edqoe;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] er, ers, input logic [7:0] erd,
                            input logic ecs, ewr, eoe, input logic [7:0] ea, edq, input logic edqoe);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(ers));
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(erd));
    chk({tag, ".sram_cs"}, 32'(sram_cs), 32'(ecs));
    chk({tag, ".sram_wr"}, 32'(sram_wr), 32'(ewr));
    chk({tag, ".sram_oe"}, 32'(sram_oe), 32'(eoe));
    chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(ea));
    chk({tag, ".sram_dq_o"}, 32'(sram_dq_o), 32'(edq));
    chk({tag, ".sram_dq_oe"}, 32'(sram_dq_oe), 32'(edqoe));
    // Structural invariants that must hold on every sampled cycle.
    chk({tag, ".inv_ready_onehot_valid"},
        32'(((req_ready & (req_ready - 2'd1)) == 2'b00) && ((req_ready & ~req_valid) == 2'b00)), 32'd1);
    chk({tag, ".inv_not_wr_and_oe"}, 32'(!(sram_wr && sram_oe)), 32'd1);
    chk({tag, ".inv_dq_oe_only_in_wr"}, 32'(!sram_dq_oe || (sram_wr && sram_cs)), 32'd1);
    chk({tag, ".inv_rsp_onehot"}, 32'((rsp_valid & (rsp_valid - 2'd1)) == 2'b00), 32'd1);
  endtask

  task automatic drive(input logic [1:0] v, w, input logic [7:0] a0, a1, w0, w1, dqi);
    req_valid = v; req_wr = w; req_addr = {a1, a0}; req_wdata = {w1, w0}; sram_dq_i = dqi;
  endtask

  initial begin
    //           v      w      a0     a1     w0     w1     dqi  | rdy   rsp    rdata  cs wr oe addr   dq_o   dqoe
    // Write req0 0x10=0xA5, then read it back (rsp 3 cycles after grant).
    vecs.push_back(mk(2'b01,2'b01,8'h10,8'h00,8'hA5,8'h00,8'h00, 2'b01,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h10,8'hA5,1));
    vecs.push_back(mk(2'b01,2'b00,8'h10,8'h00,8'h00,8'h00,8'h00, 2'b01,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,1,0,1,8'h10,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'hA5, 2'b00,2'b00,8'h00,1,0,1,8'h10,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b01,8'hA5,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    // Read req1 0x20 while req0 queues a write to 0x20: TURN (cs=0, dq_oe=0) precedes the WR.
    vecs.push_back(mk(2'b10,2'b00,8'h00,8'h20,8'h00,8'h00,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h00,8'h3C,8'h00,8'h00, 2'b00,2'b00,8'h00,1,0,1,8'h20,8'h00,0));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h00,8'h3C,8'h00,8'h5A, 2'b00,2'b00,8'h00,1,0,1,8'h20,8'h00,0));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h00,8'h3C,8'h00,8'h00, 2'b00,2'b10,8'h5A,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h00,8'h3C,8'h00,8'h00, 2'b01,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h20,8'h3C,1));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    // Only req1 active for 4 writes: granted on every IDLE visit.
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h41,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h42,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h30,8'h41,1));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h42,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h43,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h30,8'h42,1));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h43,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h44,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h30,8'h43,1));
    vecs.push_back(mk(2'b10,2'b10,8'h00,8'h30,8'h00,8'h44,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h30,8'h44,1));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    // req0 and req1 writing continuously from pointer 0: grants 0,1,0,1 with wrap.
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b01,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h01,8'h11,1));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h02,8'h22,1));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b01,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h01,8'h11,1));
    vecs.push_back(mk(2'b11,2'b11,8'h01,8'h02,8'h11,8'h22,8'h00, 2'b10,2'b00,8'h00,0,0,0,8'h00,8'h00,0));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,1,1,0,8'h02,8'h22,1));
    vecs.push_back(mk(2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 2'b00,2'b00,8'h00,0,0,0,8'h00,8'h00,0));

    rst_n = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outs("post_reset", 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].w, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1, vecs[i].dqi);
      #1 check_outs($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_rsp, vecs[i].e_rd,
                    vecs[i].e_cs, vecs[i].e_wr, vecs[i].e_oe, vecs[i].e_addr, vecs[i].e_dqo, vecs[i].e_dqoe);
    end

    // Reset asserted mid-RD_CAP: outputs drop at once, the read never responds.
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 check_outs("rst_grant", 2'b01, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 check_outs("rst_rd_addr", 2'b00, 2'b00, 8'h00, 1, 0, 1, 8'h40, 8'h00, 0);
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h77);
    #1 check_outs("rst_rd_cap", 2'b00, 2'b00, 8'h00, 1, 0, 1, 8'h40, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_async_drop", 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    #1 check_outs("rst_held", 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_outs($sformatf("rst_quiet%0d", i), 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    end
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 check_outs("after_grant", 2'b01, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 check_outs("after_rd_addr", 2'b00, 2'b00, 8'h00, 1, 0, 1, 8'h40, 8'h00, 0);
    @(negedge clk);
    sram_dq_i = 8'h99;
    #1 check_outs("after_rd_cap", 2'b00, 2'b00, 8'h00, 1, 0, 1, 8'h40, 8'h00, 0);
    @(negedge clk);
    sram_dq_i = 8'h00;
    #1 check_outs("after_turn", 2'b00, 2'b01, 8'h99, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    #1 check_outs("after_idle", 2'b00, 2'b00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
